// File: rtl/fetch_queue.sv
// fetch_queue
// Instruction fetch queue between the IF and ID stages. It buffers up to
// DEPTH (instruction, pc) pairs so that IF keeps fetching while ID stalls.
// A taken branch (flush) throws away every buffered wrong-path word.
//
// Ports:
//   clock           rising-edge clock
//   reset           synchronous, active-high reset
//   in_valid        IF presents a fetched word this cycle
//   in_instruction  fetched instruction
//   in_pc           PC value from IF (PC+4 of the fetched word)
//   in_ready        queue can accept a word; IF freezes its PC when low
//   flush           branch taken in EXE; discard all queued entries
//   out_valid       head entry is available to ID
//   out_instruction head instruction, 0 when out_valid is low
//   out_pc          head PC, 0 when out_valid is low
//   out_ready       ID consumes the head this cycle
//   count           number of valid entries, 0..DEPTH
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_instruction,
  input  logic [WIDTH-1:0]           in_pc,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_instruction,
  output logic [WIDTH-1:0]           out_pc,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // Each entry holds the instruction in the upper half and the PC in the lower half.
  logic [2*WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic [2*WIDTH-1:0] head;
  logic               push;
  logic               pop;

  // in_ready depends on the registered count only, so IF's PC-freeze path
  // never sees a combinational dependency on ID's stall or on the branch.
  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  assign head            = storage[rd_ptr];
  assign out_instruction = out_valid ? head[2*WIDTH-1:WIDTH] : '0;
  assign out_pc          = out_valid ? head[WIDTH-1:0]       : '0;

  // Reset beats flush, and flush beats any push or pop in the same cycle.
  // Flush leaves storage untouched; the zeroed count hides stale entries.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        storage[wr_ptr] <= {in_instruction, in_pc};
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
// Directed self-checking bench for fetch_queue (DEPTH=4, WIDTH=32).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_fetch_queue;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instruction;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        out_ready;
  logic [2:0]  count;

  int compared;
  int mismatched;

  fetch_queue #(.DEPTH(4), .WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_instruction(in_instruction),
    .in_pc(in_pc),
    .in_ready(in_ready),
    .flush(flush),
    .out_valid(out_valid),
    .out_instruction(out_instruction),
    .out_pc(out_pc),
    .out_ready(out_ready),
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog so a broken design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                               input logic [31:0] pc, input logic rdy,
                               input logic flsh);
    in_valid       = valid;
    in_instruction = instr;
    in_pc          = pc;
    out_ready      = rdy;
    flush          = flsh;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Reset held two cycles while IF keeps presenting a word.
    reset = 1'b1;
    applyStimulus(1'b1, 32'h99, 32'h4, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_out_instr", out_instruction, 32'h0);
    checkOutput("reset_out_pc", out_pc, 32'h0);
    reset = 1'b0;

    // Fill to full with ID stalled.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hA0 + 32'(i), 32'(4 * (i + 1)), 1'b0, 1'b0);
      tick();
      checkOutput("fill_count", 32'(count), 32'(i + 1));
    end
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 32'hA4, 32'd20, 1'b0, 1'b0);
    tick();
    checkOutput("full_count_hold", 32'(count), 32'd4);
    checkOutput("full_head", out_instruction, 32'hA0);

    // Drain in order; in_ready recovers one cycle after the first pop.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("drain_valid", 32'(out_valid), 32'd1);
      checkOutput("drain_instr", out_instruction, 32'hA0 + 32'(i));
      checkOutput("drain_pc", out_pc, 32'(4 * (i + 1)));
      tick();
      if (i == 0) checkOutput("drain_in_ready", 32'(in_ready), 32'd1);
    end
    checkOutput("drained_count", 32'(count), 32'd0);
    checkOutput("drained_valid", 32'(out_valid), 32'd0);
    checkOutput("drained_instr", out_instruction, 32'h0);

    // Prime two entries, then ten cycles of simultaneous push and pop.
    applyStimulus(1'b1, 32'hC0, 32'h100, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'hC1, 32'h104, 1'b0, 1'b0);
    tick();
    checkOutput("pp_prime_count", 32'(count), 32'd2);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 32'hC2 + 32'(k), 32'h108 + 32'(4 * k), 1'b1, 1'b0);
      checkOutput("pp_instr", out_instruction, 32'hC0 + 32'(k));
      checkOutput("pp_pc", out_pc, 32'h100 + 32'(4 * k));
      tick();
      checkOutput("pp_count", 32'(count), 32'd2);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("pp_tail0", out_instruction, 32'hCA);
    tick();
    checkOutput("pp_tail1", out_instruction, 32'hCB);
    checkOutput("pp_tail1_pc", out_pc, 32'h12C);
    tick();
    checkOutput("pp_empty", 32'(count), 32'd0);

    // Push into an empty queue: no same-cycle bypass, head next cycle.
    applyStimulus(1'b1, 32'h1234, 32'h40, 1'b0, 1'b0);
    checkOutput("empty_push_valid_n", 32'(out_valid), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("empty_push_valid_n1", 32'(out_valid), 32'd1);
    checkOutput("empty_push_instr", out_instruction, 32'h1234);
    checkOutput("empty_push_pc", out_pc, 32'h40);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("empty_push_popped", 32'(count), 32'd0);

    // Flush with three entries while IF pushes and ID pops.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hD0 + 32'(i), 32'h80 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    checkOutput("pre_flush_count", 32'(count), 32'd3);
    applyStimulus(1'b1, 32'hD3, 32'h8C, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 32'hB0, 32'h200, 1'b0, 1'b0);
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    checkOutput("flush_instr", out_instruction, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("post_flush_valid", 32'(out_valid), 32'd1);
    checkOutput("post_flush_instr", out_instruction, 32'hB0);
    checkOutput("post_flush_pc", out_pc, 32'h200);
    checkOutput("post_flush_count", 32'(count), 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();

    // Reset mid-operation together with flush and a push.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hE0 + 32'(i), 32'h280 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    checkOutput("pre_reset_count", 32'(count), 32'd3);
    reset = 1'b1;
    applyStimulus(1'b1, 32'hE3, 32'h28C, 1'b0, 1'b1);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("mid_reset_count", 32'(count), 32'd0);
    checkOutput("mid_reset_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_reset_pc", out_pc, 32'h0);
    checkOutput("mid_reset_instr", out_instruction, 32'h0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'hF0 + 32'(i), 32'h300 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    checkOutput("after_reset_count", 32'(count), 32'd2);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("after_reset_instr", out_instruction, 32'hF0 + 32'(i));
      checkOutput("after_reset_pc", out_pc, 32'h300 + 32'(4 * i));
      tick();
    end
    checkOutput("final_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
